// File: rtl/mipi_raw10_packer.sv
// RAW10 transmit packer: four 10-bit pixels become five CSI-2 bytes, which are
// buffered and drained two per 16-bit word with backpressure on both sides.
module mipi_raw10_packer (
  input  logic        I_CLK,
  input  logic        I_Rst_n,
  input  logic [39:0] I_Pixel_Data,
  input  logic        I_Pixel_Vaild,
  output logic        O_Pixel_Ready,
  input  logic        I_Mipi_Sync,
  input  logic        I_Flush,
  output logic [15:0] O_Mipi_Packet_Data,
  output logic        O_Mipi_Packet_Vaild,
  input  logic        I_Mipi_Packet_Ready
);

  localparam int unsigned BUF_BYTES = 10;

  logic [BUF_BYTES-1:0][7:0] byte_buf, byte_buf_nxt, shifted;
  logic [4:0][7:0]           grp;
  logic [3:0]                byte_cnt, byte_cnt_nxt, popped, wr_idx;
  logic                      flush_pend, flush_pend_nxt;
  logic                      acc, pop, pad;

  // Upper eight bits of each pixel, then the four 2-bit LSB pairs with P0 lowest.
  assign grp[0] = I_Pixel_Data[39:32];
  assign grp[1] = I_Pixel_Data[29:22];
  assign grp[2] = I_Pixel_Data[19:12];
  assign grp[3] = I_Pixel_Data[9:2];
  assign grp[4] = {I_Pixel_Data[1:0], I_Pixel_Data[11:10],
                   I_Pixel_Data[21:20], I_Pixel_Data[31:30]};

  assign pad                 = (byte_cnt == 4'd1);
  assign O_Pixel_Ready       = (byte_cnt <= 4'd5) & ~flush_pend & ~I_Mipi_Sync;
  assign O_Mipi_Packet_Vaild = (byte_cnt >= 4'd2) | (flush_pend & pad);
  assign O_Mipi_Packet_Data  = pad ? {8'h00, byte_buf[0]} : {byte_buf[1], byte_buf[0]};

  assign acc    = I_Pixel_Vaild & O_Pixel_Ready;
  assign pop    = O_Mipi_Packet_Vaild & I_Mipi_Packet_Ready;
  assign popped = !pop ? 4'd0 : (pad ? 4'd1 : 4'd2);
  // The new group lands right behind whatever survives this cycle's pop.
  assign wr_idx = byte_cnt - popped;

  // NOTE: every variable written here gets a default first so no latch is inferred.
  always_comb begin
    shifted        = byte_buf;
    byte_buf_nxt   = byte_buf;
    byte_cnt_nxt   = byte_cnt;
    flush_pend_nxt = flush_pend;

    case (popped)
      4'd1:    shifted = {8'h00, byte_buf[BUF_BYTES-1:1]};
      4'd2:    shifted = {16'h0000, byte_buf[BUF_BYTES-1:2]};
      default: shifted = byte_buf;
    endcase

    if (I_Mipi_Sync) begin
      // Residual bytes and any same-cycle pop are abandoned.
      byte_cnt_nxt   = 4'd0;
      flush_pend_nxt = 1'b0;
    end else begin
      byte_buf_nxt = shifted;
      if (acc) begin
        for (int i = 0; i < 5; i++) begin
          byte_buf_nxt[wr_idx + 4'(i)] = grp[i];
        end
      end
      byte_cnt_nxt   = byte_cnt - popped + (acc ? 4'd5 : 4'd0);
      flush_pend_nxt = flush_pend | (I_Flush & ((byte_cnt != 4'd0) | acc));
      if (byte_cnt_nxt == 4'd0) begin
        flush_pend_nxt = 1'b0;
      end
    end
  end

  // NOTE: the byte buffer is reset too, so the idle output word reads 16'h0000.
  always_ff @(posedge I_CLK or negedge I_Rst_n) begin
    if (!I_Rst_n) begin
      byte_buf   <= '0;
      byte_cnt   <= 4'd0;
      flush_pend <= 1'b0;
    end else begin
      // NOTE: state registers use non-blocking assignments so all update together.
      byte_buf   <= byte_buf_nxt;
      byte_cnt   <= byte_cnt_nxt;
      flush_pend <= flush_pend_nxt;
    end
  end

endmodule

// File: tb/tb_mipi_raw10_packer.sv
// Bench for mipi_raw10_packer: directed cases plus random traffic, all outputs
// compared every cycle against a byte-queue reference model.
`timescale 1ns/1ps
module tb_mipi_raw10_packer;

  logic        I_CLK = 1'b0;
  logic        I_Rst_n = 1'b0;
  logic [39:0] I_Pixel_Data = '0;
  logic        I_Pixel_Vaild = 1'b0;
  logic        I_Mipi_Sync = 1'b0;
  logic        I_Flush = 1'b0;
  logic        I_Mipi_Packet_Ready = 1'b0;
  logic        O_Pixel_Ready;
  logic        O_Mipi_Packet_Vaild;
  logic [15:0] O_Mipi_Packet_Data;

  mipi_raw10_packer dut (
    .I_CLK               (I_CLK),
    .I_Rst_n             (I_Rst_n),
    .I_Pixel_Data        (I_Pixel_Data),
    .I_Pixel_Vaild       (I_Pixel_Vaild),
    .O_Pixel_Ready       (O_Pixel_Ready),
    .I_Mipi_Sync         (I_Mipi_Sync),
    .I_Flush             (I_Flush),
    .O_Mipi_Packet_Data  (O_Mipi_Packet_Data),
    .O_Mipi_Packet_Vaild (O_Mipi_Packet_Vaild),
    .I_Mipi_Packet_Ready (I_Mipi_Packet_Ready)
  );

  always #5 I_CLK = ~I_CLK;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: observed 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference model: a plain byte FIFO plus the pending-flush flag.
  logic [7:0]  mq[$];
  bit          m_fp = 1'b0;
  int          cyc = 0;
  int          n_acc = 0;
  logic [15:0] got_w[$];
  int          got_c[$];

  function automatic logic [15:0] got_at(input int i);
    return (i < got_w.size()) ? got_w[i] : 16'hxxxx;
  endfunction

  always @(negedge I_CLK) begin
    bit          m_ready, m_valid, acc, pop;
    int          sz0, px;
    logic [7:0]  lsb;
    logic [15:0] m_word;
    cyc++;
    if (!I_Rst_n) begin
      mq.delete();
      m_fp = 1'b0;
      check("rst_valid", O_Mipi_Packet_Vaild, 0);
      check("rst_data", O_Mipi_Packet_Data, 0);
    end else begin
      sz0     = mq.size();
      m_ready = (sz0 <= 5) && !m_fp && !I_Mipi_Sync;
      m_valid = (sz0 >= 2) || (m_fp && sz0 == 1);
      check("ready", O_Pixel_Ready, m_ready);
      check("valid", O_Mipi_Packet_Vaild, m_valid);
      if (m_valid) begin
        m_word = (sz0 >= 2) ? {mq[1], mq[0]} : {8'h00, mq[0]};
        check("word", O_Mipi_Packet_Data, m_word);
      end
      if (O_Mipi_Packet_Vaild && I_Mipi_Packet_Ready) begin
        got_w.push_back(O_Mipi_Packet_Data);
        got_c.push_back(cyc);
      end
      acc = I_Pixel_Vaild && m_ready;
      pop = m_valid && I_Mipi_Packet_Ready;
      if (I_Mipi_Sync) begin
        mq.delete();
        m_fp = 1'b0;
      end else begin
        if (pop) begin
          void'(mq.pop_front());
          if (sz0 >= 2) void'(mq.pop_front());
        end
        if (acc) begin
          n_acc++;
          lsb = 8'h00;
          for (int i = 0; i < 4; i++) begin
            px = int'((I_Pixel_Data >> (30 - 10 * i)) & 40'h3FF);
            mq.push_back(8'(px / 4));
            lsb = lsb + 8'((px % 4) * (1 << (2 * i)));
          end
          mq.push_back(lsb);
        end
        if (I_Flush && (sz0 != 0 || acc)) m_fp = 1'b1;
        if (mq.size() == 0) m_fp = 1'b0;
      end
    end
  end

  task automatic step();
    @(posedge I_CLK);
    #1;
  endtask

  task automatic send_group(input logic [39:0] d);
    int w;
    w = 0;
    I_Pixel_Data  = d;
    I_Pixel_Vaild = 1'b1;
    while (!O_Pixel_Ready && w < 50) begin
      step();
      w++;
    end
    check("send_ready", O_Pixel_Ready, 1);
    step();
    I_Pixel_Vaild = 1'b0;
  endtask

  task automatic drain();
    int w;
    w = 0;
    while (O_Mipi_Packet_Vaild && w < 200) begin
      step();
      w++;
    end
    check("drained", O_Mipi_Packet_Vaild, 0);
  endtask

  function automatic logic [39:0] rnd40();
    logic [63:0] r;
    r = {$urandom, $urandom};
    return r[39:0];
  endfunction

  initial begin
    logic [15:0] held;
    logic [15:0] exp2 [5];
    exp2 = '{16'h00FF, 16'hAA55, 16'hFF93, 16'h5500, 16'h93AA};

    repeat (3) @(posedge I_CLK);
    #1;
    check("rst_hold_valid", O_Mipi_Packet_Vaild, 0);
    I_Rst_n = 1'b1;
    step();
    check("post_rst_ready", O_Pixel_Ready, 1);
    check("post_rst_data", O_Mipi_Packet_Data, 16'h0000);

    // Single group followed by a flush: odd residual ends in a pad word.
    I_Mipi_Packet_Ready = 1'b1;
    got_w.delete(); got_c.delete();
    send_group(40'hFFC00556AA);
    I_Flush = 1'b1;
    step();
    I_Flush = 1'b0;
    repeat (6) step();
    check("t1_count", got_w.size(), 3);
    check("t1_w0", got_at(0), 16'h00FF);
    check("t1_w1", got_at(1), 16'hAA55);
    check("t1_pad", got_at(2), 16'h0093);
    check("t1_idle", O_Mipi_Packet_Vaild, 0);

    // Two back-to-back groups.
    got_w.delete(); got_c.delete();
    send_group(40'hFFC00556AA);
    send_group(40'hFFC00556AA);
    check("t2_ready_lo_a", O_Pixel_Ready, 0);
    step();
    check("t2_ready_lo_b", O_Pixel_Ready, 0);
    step();
    check("t2_ready_back", O_Pixel_Ready, 1);
    repeat (6) step();
    check("t2_count", got_w.size(), 5);
    for (int i = 0; i < 5; i++) begin
      check($sformatf("t2_w%0d", i), got_at(i), exp2[i]);
      if (i < got_c.size()) check($sformatf("t2_gap%0d", i), got_c[i] - got_c[0], i);
    end

    // Continuous streaming of 100 random groups.
    got_w.delete(); got_c.delete();
    for (int g = 0; g < 100; g++) send_group(rnd40());
    drain();
    check("t3_count", got_w.size(), 250);
    if (got_c.size() == 250) check("t3_no_gaps", got_c[249] - got_c[0], 249);

    // Backpressure: downstream stalled while input keeps offering.
    I_Mipi_Packet_Ready = 1'b0;
    got_w.delete(); got_c.delete();
    n_acc = 0;
    I_Pixel_Vaild = 1'b1;
    for (int i = 0; i < 10; i++) begin
      I_Pixel_Data = rnd40();
      step();
    end
    check("t4_accepts", n_acc, 2);
    check("t4_byte_cnt", dut.byte_cnt, 10);
    check("t4_ready_lo", O_Pixel_Ready, 0);
    held = O_Mipi_Packet_Data;
    for (int i = 0; i < 3; i++) begin
      step();
      check("t4_stable", O_Mipi_Packet_Data, held);
    end
    I_Pixel_Vaild = 1'b0;
    I_Mipi_Packet_Ready = 1'b1;
    drain();
    check("t4_count", got_w.size(), 5);
    check("t4_first", got_at(0), held);

    // Sync with 7 bytes buffered and a group offered in the same cycle.
    send_group(rnd40());
    send_group(rnd40());
    step();
    step();
    send_group(rnd40());
    check("t5_byte_cnt7", dut.byte_cnt, 7);
    I_Pixel_Data  = rnd40();
    I_Pixel_Vaild = 1'b1;
    I_Mipi_Sync   = 1'b1;
    check("t5_ready_sync", O_Pixel_Ready, 0);
    step();
    I_Mipi_Sync   = 1'b0;
    I_Pixel_Vaild = 1'b0;
    check("t5_valid", O_Mipi_Packet_Vaild, 0);
    check("t5_byte_cnt0", dut.byte_cnt, 0);
    repeat (3) step();
    check("t5_quiet", O_Mipi_Packet_Vaild, 0);

    // Asynchronous reset in the middle of a stream.
    send_group(rnd40());
    send_group(rnd40());
    I_Pixel_Vaild = 1'b1;
    check("t6_busy", O_Mipi_Packet_Vaild, 1);
    #2 I_Rst_n = 1'b0;
    #1;
    check("t6_async_valid", O_Mipi_Packet_Vaild, 0);
    check("t6_async_data", O_Mipi_Packet_Data, 16'h0000);
    I_Pixel_Vaild = 1'b0;
    step();
    step();
    I_Rst_n = 1'b1;
    got_w.delete(); got_c.delete();
    send_group(40'hFFC00556AA);
    step();
    check("t6_first_word", got_at(0), 16'h00FF);
    I_Flush = 1'b1;
    step();
    I_Flush = 1'b0;
    drain();

    // Random mixed traffic with flushes and syncs.
    for (int i = 0; i < 1500; i++) begin
      I_Pixel_Data        = rnd40();
      I_Pixel_Vaild       = $urandom_range(0, 1) == 1;
      I_Mipi_Packet_Ready = $urandom_range(0, 3) != 0;
      I_Flush             = $urandom_range(0, 15) == 0;
      I_Mipi_Sync         = $urandom_range(0, 63) == 0;
      step();
    end
    I_Pixel_Vaild = 1'b0;
    I_Mipi_Sync = 1'b0;
    I_Mipi_Packet_Ready = 1'b1;
    I_Flush = 1'b1;
    step();
    I_Flush = 1'b0;
    drain();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation exceeded its time limit");
    $fatal(1, "watchdog");
  end

endmodule
